xgcd_arg_stream: RTL and testbench

- Parametrised successor to the XGCD core's argument storage.
- Holds NUM_ARGS argument banks of WORDS x 64-bit words, written and read through the SRAM-side port of the AXI-to-SRAM bridge.
- Adds an APB control/status register set and a sequencer. The sequencer streams word i of every bank, concatenated, to the compute engine over a valid/ready handshake.
- Raises START_OUT, DONE_OUT and IRQ.

---
 rtl/xgcd_arg_stream.sv | 196 +++++++++++++++++++
 tb/tb_xgcd_arg_stream.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xgcd_arg_stream.sv
// XGCD argument storage: NUM_ARGS banks of 64-bit words behind an SRAM-style port,
// an APB register block, and a sequencer that streams word i of every bank per beat.
module xgcd_arg_stream #(
  parameter int          NUM_ARGS = 2,
  parameter int          WORDS    = 32,
  parameter int          IDX_W    = $clog2(WORDS),
  parameter logic [31:0] ID_VALUE = 32'h5A5A0002
) (
  input  logic                     CLK,
  input  logic                     RESETn,
  input  logic [31:0]              PADDR,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [31:0]              PWDATA,
  output logic [31:0]              PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  input  logic                     SRAM_CEn,
  input  logic [31:0]              SRAM_ADDR,
  input  logic [63:0]              SRAM_WDATA,
  input  logic                     SRAM_WEn,
  input  logic [7:0]               SRAM_WBEn,
  output logic [63:0]              SRAM_RDATA,
  output logic [64*NUM_ARGS-1:0]   OP_DATA,
  output logic [IDX_W-1:0]         OP_IDX,
  output logic                     OP_VALID,
  output logic                     OP_LAST,
  input  logic                     OP_READY,
  output logic                     IRQ,
  output logic                     START_OUT,
  output logic                     DONE_OUT
);

  localparam int         BANK_W     = (NUM_ARGS > 1) ? $clog2(NUM_ARGS) : 1;
  localparam logic [4:0] NUM_ARGS_L = 5'(NUM_ARGS);
  localparam logic [9:0] WORDS_L    = 10'(WORDS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_nxt;
  logic [63:0]         mem [NUM_ARGS][WORDS];
  logic [IDX_W-1:0]    idx;
  logic                irq_en, done, err;
  logic [8:0]          len;
  logic                busy;

  logic                apb_setup, apb_rd;
  logic [9:0]          apb_off;
  logic                wr_ctrl, wr_status, wr_len;
  logic                start_req, abort_req;
  logic [31:0]         rd_mux;

  logic [3:0]          sram_bank;
  logic [BANK_W-1:0]   sram_sel;
  logic [IDX_W-1:0]    sram_word;
  logic                sram_hit, sram_wr, sram_rd, sram_wr_ok, sram_wr_err;

  logic [IDX_W-1:0]    beat_idx;
  logic [64*NUM_ARGS-1:0] beat_data;
  logic                beat_last, len_ok;
  logic                go, step, finish, abort_run, start_bad;
  logic                unused_ok;

  assign PREADY    = 1'b1;
  assign PSLVERR   = 1'b0;
  assign busy      = (state == RUN);
  assign IRQ       = done & irq_en;
  assign OP_IDX    = idx;
  assign unused_ok = ^{PADDR[31:12], PADDR[1:0], SRAM_ADDR[31:IDX_W+7], SRAM_ADDR[2:0]};

  assign apb_setup = PSEL & ~PENABLE;
  assign apb_off   = PADDR[11:2];
  assign apb_rd    = apb_setup & ~PWRITE;
  assign wr_ctrl   = apb_setup & PWRITE & (apb_off == 10'd1);
  assign wr_status = apb_setup & PWRITE & (apb_off == 10'd2);
  assign wr_len    = apb_setup & PWRITE & (apb_off == 10'd3);
  assign start_req = wr_ctrl & PWDATA[0];
  assign abort_req = wr_ctrl & PWDATA[2];

  always_comb begin
    rd_mux = '0;
    case (apb_off)
      10'd0:   rd_mux = ID_VALUE;
      10'd1:   rd_mux = {30'b0, irq_en, 1'b0};
      10'd2:   rd_mux = {29'b0, err, done, busy};
      10'd3:   rd_mux = {23'b0, len};
      default: rd_mux = '0;
    endcase
  end

  assign sram_bank   = SRAM_ADDR[3+IDX_W +: 4];
  assign sram_sel    = sram_bank[BANK_W-1:0];
  assign sram_word   = SRAM_ADDR[3 +: IDX_W];
  assign sram_hit    = ({1'b0, sram_bank} < NUM_ARGS_L);
  assign sram_wr     = ~SRAM_CEn & ~SRAM_WEn;
  assign sram_rd     = ~SRAM_CEn & SRAM_WEn;
  assign sram_wr_ok  = sram_wr & sram_hit & ~busy;
  assign sram_wr_err = sram_wr & busy;

  // Bank storage keeps its contents across reset.
  always_ff @(posedge CLK) begin
    if (sram_wr_ok) begin
      for (int j = 0; j < 8; j++) begin
        if (!SRAM_WBEn[j]) mem[sram_sel][sram_word][8*j +: 8] <= SRAM_WDATA[8*j +: 8];
      end
    end
  end

  // Next beat to present: word 0 when starting, otherwise the successor of idx.
  assign beat_idx  = (state == IDLE) ? '0 : idx + IDX_W'(1);
  assign beat_last = ((10'(beat_idx) + 10'd1) == {1'b0, len});
  assign len_ok    = (len != 9'd0) && ({1'b0, len} <= WORDS_L);

  genvar k;
  generate
    for (k = 0; k < NUM_ARGS; k++) begin : g_beat
      assign beat_data[64*k +: 64] = mem[k][beat_idx];
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    abort_run = 1'b0;
    start_bad = 1'b0;
    case (state)
      IDLE: begin
        if (start_req) begin
          if (len_ok) begin
            state_nxt = RUN;
            go        = 1'b1;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort_req) begin
          state_nxt = IDLE;
          abort_run = 1'b1;
        end else if (OP_VALID && OP_READY) begin
          if (OP_LAST) begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end else begin
            step = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered stream outputs and control/status state.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state      <= IDLE;
      idx        <= '0;
      OP_DATA    <= '0;
      OP_VALID   <= 1'b0;
      OP_LAST    <= 1'b0;
      START_OUT  <= 1'b0;
      DONE_OUT   <= 1'b0;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      len        <= '0;
      PRDATA     <= '0;
      SRAM_RDATA <= '0;
    end else begin
      state     <= state_nxt;
      START_OUT <= go;
      DONE_OUT  <= finish;
      if (go || step) begin
        idx      <= beat_idx;
        OP_DATA  <= beat_data;
        OP_LAST  <= beat_last;
        OP_VALID <= 1'b1;
      end else if (finish || abort_run) begin
        OP_VALID <= 1'b0;
        OP_LAST  <= 1'b0;
      end
      if (wr_ctrl) irq_en <= PWDATA[1];
      if (wr_len && !busy) len <= PWDATA[8:0];
      // Hardware set beats a same-cycle write-1-to-clear.
      done <= finish | (done & ~(wr_status & PWDATA[1]));
      err  <= start_bad | abort_run | sram_wr_err | (err & ~(wr_status & PWDATA[2]));
      if (apb_rd) PRDATA <= rd_mux;
      if (sram_rd) SRAM_RDATA <= sram_hit ? mem[sram_sel][sram_word] : '0;
    end
  end

endmodule

// File: tb/tb_xgcd_arg_stream.sv
// Directed bench for xgcd_arg_stream: APB registers, SRAM port, and beat streaming.
module tb_xgcd_arg_stream;

  logic         CLK;
  logic         RESETn;
  logic [31:0]  PADDR;
  logic         PSEL, PENABLE, PWRITE;
  logic [31:0]  PWDATA, PRDATA;
  logic         PREADY, PSLVERR;
  logic         SRAM_CEn, SRAM_WEn;
  logic [31:0]  SRAM_ADDR;
  logic [63:0]  SRAM_WDATA, SRAM_RDATA;
  logic [7:0]   SRAM_WBEn;
  logic [127:0] OP_DATA;
  logic [4:0]   OP_IDX;
  logic         OP_VALID, OP_LAST, OP_READY;
  logic         IRQ, START_OUT, DONE_OUT;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  logic [63:0] d;

  xgcd_arg_stream #(.NUM_ARGS(2), .WORDS(32)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .SRAM_CEn(SRAM_CEn), .SRAM_ADDR(SRAM_ADDR), .SRAM_WDATA(SRAM_WDATA),
    .SRAM_WEn(SRAM_WEn), .SRAM_WBEn(SRAM_WBEn), .SRAM_RDATA(SRAM_RDATA),
    .OP_DATA(OP_DATA), .OP_IDX(OP_IDX), .OP_VALID(OP_VALID), .OP_LAST(OP_LAST),
    .OP_READY(OP_READY), .IRQ(IRQ), .START_OUT(START_OUT), .DONE_OUT(DONE_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Setup phase is sampled on the tick; PENABLE is left high for the access phase.
  task automatic apb_setup(input int off, input logic [31:0] data, input logic wr);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
    PADDR = 32'(off) << 2; PWDATA = data;
    tick();
    PENABLE = 1'b1;
  endtask

  task automatic apb_idle();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_write(input int off, input logic [31:0] data);
    apb_setup(off, data, 1'b1);
    tick();
    apb_idle();
  endtask

  task automatic apb_read(input int off, output logic [31:0] data);
    apb_setup(off, 32'h0, 1'b0);
    data = PRDATA;
    tick();
    apb_idle();
  endtask

  function automatic logic [31:0] addr(input int bank, input int word);
    return (32'(bank) << 8) | (32'(word) << 3);
  endfunction

  function automatic logic [127:0] beat(input int i);
    return {64'h2000 + 64'(i), 64'h1000 + 64'(i)};
  endfunction

  task automatic sram_write(input logic [31:0] a, input logic [63:0] data, input logic [7:0] wben);
    SRAM_ADDR = a; SRAM_WDATA = data; SRAM_WBEn = wben;
    SRAM_CEn = 1'b0; SRAM_WEn = 1'b0;
    tick();
    SRAM_CEn = 1'b1; SRAM_WEn = 1'b1; SRAM_WBEn = 8'hFF;
  endtask

  task automatic sram_read(input logic [31:0] a, output logic [63:0] data);
    SRAM_ADDR = a; SRAM_CEn = 1'b0; SRAM_WEn = 1'b1;
    tick();
    SRAM_CEn = 1'b1;
    data = SRAM_RDATA;
  endtask

  initial begin
    int hs;
    int cyc;
    RESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    SRAM_CEn = 1'b1; SRAM_WEn = 1'b1; SRAM_WBEn = 8'hFF; SRAM_ADDR = '0; SRAM_WDATA = '0;
    OP_READY = 1'b0;
    repeat (3) tick();
    chk("rst_prdata", PRDATA, 0);
    chk("rst_sram_rdata", SRAM_RDATA, 0);
    chk("rst_op_data", OP_DATA, 0);
    chk("rst_op_idx", OP_IDX, 0);
    chk("rst_flags", {OP_VALID, OP_LAST, START_OUT, DONE_OUT, IRQ}, 0);
    chk("apb_ready_err", {PREADY, PSLVERR}, 2'b10);
    RESETn = 1'b1;
    tick();

    apb_read(0, rd); chk("id", rd, 32'h5A5A0002);
    apb_read(1, rd); chk("ctrl_rst", rd, 0);
    apb_read(2, rd); chk("status_rst", rd, 0);
    apb_read(3, rd); chk("len_rst", rd, 0);
    apb_read(9, rd); chk("unmapped_off", rd, 0);

    for (int i = 0; i < 4; i++) begin
      sram_write(addr(0, i), 64'h1000 + 64'(i), 8'h00);
      sram_write(addr(1, i), 64'h2000 + 64'(i), 8'h00);
    end
    sram_write(addr(0, 2), 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0);
    sram_read(addr(0, 2), d); chk("byte_en", d, 64'h0000_0000_FFFF_FFFF);
    tick(); chk("rdata_hold", SRAM_RDATA, 64'h0000_0000_FFFF_FFFF);
    sram_write(addr(0, 2), 64'h1002, 8'h00);
    sram_write(addr(2, 0), 64'hBAD0, 8'h00);
    sram_read(addr(0, 0), d); chk("unmapped_wr_ignored", d, 64'h1000);
    sram_read(addr(2, 0), d); chk("unmapped_rd_zero", d, 0);
    sram_read(addr(1, 3), d); chk("bank1_w3", d, 64'h2003);

    // Run with consumer always ready
    OP_READY = 1'b1;
    apb_write(3, 32'd4);
    apb_setup(1, 32'h3, 1'b1);
    chk("r1_start_out", START_OUT, 1);
    chk("r1_b0", {OP_VALID, OP_LAST, OP_IDX, OP_DATA}, {1'b1, 1'b0, 5'd0, beat(0)});
    for (int i = 1; i < 4; i++) begin
      tick();
      apb_idle();
      chk("r1_pulses", {START_OUT, DONE_OUT}, 0);
      chk("r1_beat", {OP_VALID, OP_LAST, OP_IDX, OP_DATA}, {1'b1, (i == 3), 5'(i), beat(i)});
    end
    tick();
    chk("r1_end", {OP_VALID, OP_LAST, DONE_OUT, IRQ}, 4'b0011);
    tick();
    chk("r1_after", {DONE_OUT, IRQ}, 2'b01);
    OP_READY = 1'b0;
    apb_read(2, rd); chk("r1_status", rd, 32'h2);
    apb_write(2, 32'h2);
    chk("r1_irq_clr", IRQ, 0);
    apb_read(2, rd); chk("r1_status_clr", rd, 0);

    // Run with alternating ready: every beat must hold while stalled
    apb_setup(1, 32'h3, 1'b1);
    tick();
    apb_idle();
    hs = 0;
    cyc = 0;
    while (hs < 4 && cyc < 40) begin
      OP_READY = (cyc % 2 == 1);
      chk("r2_beat", {OP_VALID, OP_LAST, OP_IDX, OP_DATA}, {1'b1, (hs == 3), 5'(hs), beat(hs)});
      tick();
      if (OP_READY) hs++;
      cyc++;
    end
    OP_READY = 1'b0;
    chk("r2_handshakes", hs, 4);
    chk("r2_end", {OP_VALID, DONE_OUT}, 2'b01);
    tick();
    chk("r2_no_extra", {OP_VALID, DONE_OUT}, 2'b00);
    apb_write(2, 32'h2);

    // Illegal lengths
    apb_write(3, 32'd0);
    apb_write(1, 32'h1);
    apb_read(2, rd); chk("len0_err", rd, 32'h4);
    chk("len0_idle", OP_VALID, 0);
    apb_write(2, 32'h4);
    apb_write(3, 32'd33);
    apb_write(1, 32'h1);
    apb_read(2, rd); chk("len33_err", rd, 32'h4);
    apb_write(2, 32'h4);
    apb_read(2, rd); chk("err_clr", rd, 0);

    // SRAM write while busy, LEN write while busy, abort after two beats
    apb_write(3, 32'd4);
    apb_write(1, 32'h1);
    sram_write(addr(0, 1), 64'hDEAD, 8'h00);
    apb_read(2, rd); chk("busy_wr_err", rd, 32'h5);
    apb_write(3, 32'd7);
    OP_READY = 1'b1;
    tick();
    tick();
    OP_READY = 1'b0;
    chk("r3_b2", {OP_VALID, OP_IDX}, {1'b1, 5'd2});
    apb_setup(1, 32'h4, 1'b1);
    chk("abort_stop", {OP_VALID, DONE_OUT}, 2'b00);
    tick();
    apb_idle();
    apb_read(2, rd); chk("abort_status", rd, 32'h4);
    apb_read(3, rd); chk("len_busy_ignored", rd, 32'd4);
    sram_read(addr(0, 1), d); chk("busy_wr_dropped", d, 64'h1001);
    apb_write(2, 32'h4);

    // START and ABORT together from IDLE: START wins; then reset mid-run
    apb_setup(1, 32'h5, 1'b1);
    chk("start_abort", {OP_VALID, START_OUT}, 2'b11);
    tick();
    apb_idle();
    OP_READY = 1'b1;
    tick();
    OP_READY = 1'b0;
    chk("r4_b1", {OP_VALID, OP_IDX, OP_DATA}, {1'b1, 5'd1, beat(1)});
    RESETn = 1'b0;
    tick();
    chk("midrst_flags", {OP_VALID, OP_LAST, START_OUT, DONE_OUT, IRQ}, 0);
    chk("midrst_data", {OP_IDX, OP_DATA}, 0);
    RESETn = 1'b1;
    tick();
    chk("midrst_no_done", DONE_OUT, 0);
    apb_read(2, rd); chk("midrst_status", rd, 0);
    apb_read(3, rd); chk("midrst_len", rd, 0);
    sram_read(addr(1, 3), d); chk("midrst_bank1", d, 64'h2003);
    sram_read(addr(0, 0), d); chk("midrst_bank0", d, 64'h1000);

    // ABORT in IDLE does nothing
    apb_write(1, 32'h4);
    apb_read(2, rd); chk("abort_idle", rd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
